// File: rtl/softmax_normalizer.sv
// Buffers one frame of pseudo-exponential values, sums them, then emits each
// element's probability floor(val*2^OUT_W/sum) using one shared restoring divider.
module softmax_normalizer #(
    parameter int N     = 4,
    parameter int OUT_W = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [2:0]                        mant_in,
    input  logic [2:0]                        exp_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUT_W-1:0]                  prob_out,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_idx,
    output logic                              out_last,
    output logic                              busy
);

    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int DEPTH  = 2 ** IDX_W;
    localparam int SUM_W  = 11 + $clog2(N);
    localparam int REM_W  = SUM_W + 1;
    localparam int STEP_W = $clog2(OUT_W + 2);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(OUT_W + 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DIV     = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [10:0]       val_buf [DEPTH];
    logic [SUM_W-1:0]  sum;
    logic [IDX_W-1:0]  count;
    logic [IDX_W-1:0]  idx;
    logic [STEP_W-1:0] step;
    logic [REM_W-1:0]  rem;
    logic [OUT_W:0]    quot;

    logic [10:0]       in_val;
    logic              accept;
    logic              rem_ge;
    logic [REM_W-1:0]  rem_sel;
    logic [REM_W-1:0]  rem_next;
    logic [OUT_W-1:0]  prob_sat;

    assign in_val   = 11'({1'b1, mant_in}) << exp_in;
    assign accept   = in_valid && in_ready;
    assign rem_ge   = rem >= REM_W'(sum);
    assign rem_sel  = rem_ge ? (rem - REM_W'(sum)) : rem;
    assign rem_next = rem_sel << 1;
    // A quotient of exactly 2^OUT_W only happens when the element is the whole sum.
    assign prob_sat = quot[OUT_W] ? '1 : quot[OUT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        prob_out  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (accept && count == LAST_IDX) begin
                    state_nxt = DIV;
                end
            end
            DIV: begin
                busy = 1'b1;
                if (step == LAST_STEP) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                prob_out  = prob_sat;
                out_idx   = idx;
                out_last  = (idx == LAST_IDX);
                if (out_ready) begin
                    state_nxt = (idx == LAST_IDX) ? COLLECT : DIV;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Step 0 of DIV loads the element; steps 1..OUT_W+1 each retire one quotient bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            count <= '0;
            idx   <= '0;
            step  <= '0;
            rem   <= '0;
            quot  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    step <= '0;
                    if (accept) begin
                        sum   <= sum + SUM_W'(in_val);
                        count <= (count == LAST_IDX) ? '0 : count + 1'b1;
                    end
                end
                DIV: begin
                    if (step == '0) begin
                        rem  <= REM_W'(val_buf[idx]);
                        quot <= '0;
                        step <= step + 1'b1;
                    end else begin
                        rem  <= rem_next;
                        quot <= {quot[OUT_W-1:0], rem_ge};
                        step <= (step == LAST_STEP) ? '0 : step + 1'b1;
                    end
                end
                OUT: begin
                    step <= '0;
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            sum   <= '0;
                            count <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    sum   <= '0;
                    count <= '0;
                    idx   <= '0;
                    step  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            val_buf[count] <= in_val;
        end
    end

endmodule

// File: tb/tb_softmax_normalizer.sv
// Scoreboard bench for softmax_normalizer: an N=4 instance for the main frames
// and an N=1 instance for the saturation case.
module tb_softmax_normalizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [2:0] mant_in, exp_in;
    logic [7:0] prob_out;
    logic [1:0] out_idx;

    logic       in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_last_s, busy_s;
    logic [2:0] mant_in_s, exp_in_s;
    logic [7:0] prob_out_s;
    logic [0:0] out_idx_s;

    softmax_normalizer #(.N(4), .OUT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mant_in(mant_in), .exp_in(exp_in), .out_valid(out_valid),
        .out_ready(out_ready), .prob_out(prob_out), .out_idx(out_idx),
        .out_last(out_last), .busy(busy)
    );

    softmax_normalizer #(.N(1), .OUT_W(8)) dut_single (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .mant_in(mant_in_s), .exp_in(exp_in_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s), .prob_out(prob_out_s), .out_idx(out_idx_s),
        .out_last(out_last_s), .busy(busy_s)
    );

    typedef struct {
        int prob;
        int idx;
        int last;
    } expect_t;

    expect_t sb[$];
    expect_t sb_s[$];
    expect_t mon_e;
    expect_t mon_es;
    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitors compare every completed output handshake against the queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("prob", int'(prob_out), mon_e.prob);
                checkOutput("idx", int'(out_idx), mon_e.idx);
                checkOutput("last", int'(out_last), mon_e.last);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_s && out_ready_s) begin
            if (sb_s.size() == 0) begin
                checkOutput("unexpected_output_single", 1, 0);
            end else begin
                mon_es = sb_s.pop_front();
                checkOutput("single_prob", int'(prob_out_s), mon_es.prob);
                checkOutput("single_idx", int'(out_idx_s), mon_es.idx);
                checkOutput("single_last", int'(out_last_s), mon_es.last);
            end
        end
    end

    task automatic pushFrame(input int p0, input int p1, input int p2, input int p3);
        int p[4];
        p = '{p0, p1, p2, p3};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{prob: p[i], idx: i, last: (i == 3) ? 1 : 0});
        end
    endtask

    task automatic applyStimulus(input logic [2:0] m, input logic [2:0] e);
        int waited = 0;
        in_valid = 1'b1;
        mant_in  = m;
        exp_in   = e;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitOutValid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!out_valid) checkOutput("out_valid_timeout", 0, 1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain_remaining", sb.size(), 0);
        checkOutput("in_ready_after_frame", int'(in_ready), 1);
    endtask

    initial begin
        int cyc;
        int n;
        rst = 1'b1;
        in_valid = 1'b0; mant_in = '0; exp_in = '0; out_ready = 1'b1;
        in_valid_s = 1'b0; mant_in_s = '0; exp_in_s = '0; out_ready_s = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_prob", int'(prob_out), 0);
        checkOutput("reset_idx", int'(out_idx), 0);
        checkOutput("reset_last", int'(out_last), 0);
        checkOutput("reset_busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] uniform frame");
        pushFrame(64, 64, 64, 64);
        for (int i = 0; i < 4; i++) applyStimulus(3'd0, 3'd0);
        checkOutput("in_ready_after_last_beat", int'(in_ready), 0);
        waitOutValid(cyc);
        checkOutput("first_latency", cyc, 10);
        waitDrain();

        $display("[TB] skewed frame");
        pushFrame(186, 23, 23, 23);
        applyStimulus(3'd0, 3'd3);
        for (int i = 0; i < 3; i++) applyStimulus(3'd0, 3'd0);
        waitDrain();

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        pushFrame(186, 23, 23, 23);
        applyStimulus(3'd0, 3'd3);
        for (int i = 0; i < 3; i++) applyStimulus(3'd0, 3'd0);
        waitOutValid(cyc);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        waitOutValid(cyc);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_prob", int'(prob_out), 23);
            checkOutput("bp_idx", int'(out_idx), 1);
            checkOutput("bp_in_ready", int'(in_ready), 0);
            in_valid = 1'b1; mant_in = 3'd7; exp_in = 3'd7;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        waitDrain();

        $display("[TB] max values");
        pushFrame(64, 64, 64, 64);
        for (int i = 0; i < 4; i++) applyStimulus(3'd7, 3'd7);
        waitDrain();

        $display("[TB] reset mid-division");
        for (int i = 0; i < 4; i++) applyStimulus(3'd5, 3'd1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("pre_reset_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_out_valid", int'(out_valid), 0);
        checkOutput("midreset_in_ready", int'(in_ready), 1);
        checkOutput("midreset_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pushFrame(64, 64, 64, 64);
        for (int i = 0; i < 4; i++) applyStimulus(3'd0, 3'd0);
        waitDrain();

        $display("[TB] single-element saturation");
        sb_s.push_back('{prob: 255, idx: 0, last: 1});
        in_valid_s = 1'b1; mant_in_s = 3'd3; exp_in_s = 3'd2;
        checkOutput("single_in_ready", int'(in_ready_s), 1);
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        n = 0;
        while (sb_s.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("single_drain_remaining", sb_s.size(), 0);
        checkOutput("single_in_ready_after", int'(in_ready_s), 1);
        checkOutput("single_out_valid_after", int'(out_valid_s), 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
